hpi_target: RTL and testbench
=============================

// Module: hpi_target
// PURPOSE
//  Target (chip-side) end of the OTG host-port interface (HPI) bus the lab8 SoC drives through its PIOs.
//  Decodes cs/rd/wr/address strobes, provides auto-incrementing word RAM, address, mailbox and status registers.
//  Used as a synthesizable stand-in for the USB controller in simulation and loopback bring-up; a device-side mailbox port models firmware.
// PARAMETERS
//  DEPTH   256  RAM size in 16-bit words (power of 2); byte address wraps modulo 2*DEPTH
//  RD_LAT  2    cycles from first sampled rd_n low to data_out valid (>=1)
// PORTS
//  Clk             in   1   system clock; all logic on rising edge
//  Reset           in   1   synchronous, active-high reset
//  hpi_cs_n        in   1   chip select, active low
//  hpi_rd_n        in   1   read strobe, active low
//  hpi_wr_n        in   1   write strobe, active low
//  hpi_addr        in   2   0=DATA 1=MAILBOX 2=ADDRESS 3=STATUS
//  hpi_data_in     in   16  write data from host
//  hpi_data_out    out  16  read data to host
//  hpi_data_oe     out  1   target drives bus (for tristate in top level)
//  dev_mbx_wr      in   1   device pulse: load host-bound mailbox
//  dev_mbx_wdata   in   16  word for host-bound mailbox
//  dev_mbx_rd      in   1   device pulse: pop host-to-device mailbox
//  dev_mbx_rdata   out  16  host-to-device mailbox contents
//  dev_mbx_valid   out  1   host-to-device mailbox full
//  dev_irq         out  1   host-bound mailbox full (HPI interrupt)
// BEHAVIOUR
//  Reset: all outputs 0, addr_reg=0, both mailboxes empty, error=0, FSM=IDLE; strobe history regs reset to "low seen", so a strobe held low through reset is ignored until it goes high then low.
//  Access start = cycle with cs_n=0 and rd_n or wr_n newly low (was high previous cycle). Access end = first cycle strobe or cs_n high.
//  FSM: IDLE -> RD_WAIT (start, rd) -> RD_HOLD (after RD_LAT) -> IDLE (end); IDLE -> WR_HOLD (start, wr) -> IDLE (end). End in RD_WAIT aborts to IDLE, no side effects.
//  Write at start cycle: DATA -> RAM[addr_reg[AW:1]] <= data_in; MAILBOX -> h2d mbx, dev_mbx_valid=1; ADDRESS -> addr_reg; STATUS ignored.
//  Read: hpi_data_oe=1 from cycle after start until cycle after end; hpi_data_out=0 until RD_LAT cycles after start, then register value held stable until end.
//  STATUS read = {error,13'b0,dev_mbx_valid,dev_irq}; read has no side effects. ADDRESS read returns addr_reg.
//  DATA access (rd or wr) increments addr_reg by 2 at end; addr_reg[0] ignored for RAM index; index wraps DEPTH-1 -> 0, addr_reg itself wraps at 16 bits.
//  MAILBOX read returns d2h word; dev_irq clears at end of that read.
//  dev_mbx_wr same cycle as d2h clear: write wins, dev_irq stays 1, new data. Overwrite of full mailbox: new data, flag stays 1.
//  Host MAILBOX write same cycle as dev_mbx_rd: write wins, dev_mbx_valid stays 1.
//  rd_n and wr_n both low at start: no access, error bit sets (sticky until Reset), FSM stays IDLE.
//  Reset mid-access: next cycle data_oe=0, FSM=IDLE, no pending increment or write completes.
// STRUCTURE
//  hpi_pkg: hpi_reg_e (DATA/MAILBOX/ADDRESS/STATUS), status bit positions, hpi_state_e (IDLE/RD_WAIT/RD_HOLD/WR_HOLD).
//  Sub-module hpi_ram: single-port sync RAM, DEPTH x 16, 1-cycle read; remaining latency padded in hpi_target.
// TESTING
//  Write ADDRESS 0x0010, DATA 0xBEEF, DATA 0x1234; ADDRESS 0x0010; read DATA x2 -> 0xBEEF, 0x1234; read ADDRESS -> 0x0014.
//  Read with rd_n low at cycle t -> data_oe=1 at t+1, data_out=0 before t+RD_LAT, valid from t+RD_LAT, oe=0 cycle after rd_n high.
//  Host writes MAILBOX 0xA5A5 -> dev_mbx_valid=1, rdata=0xA5A5, STATUS=0x0002; dev_mbx_rd -> valid=0.
//  dev_mbx_wr 0x5A5A -> dev_irq=1; host reads MAILBOX -> 0x5A5A, dev_irq=0 after strobe end; repeat with dev_mbx_wr at end cycle -> irq stays 1.
//  DEPTH=256: ADDRESS 0x01FE, write DATA 0x1111, 0x2222 -> RAM[255]=0x1111, RAM[0]=0x2222, addr_reg=0x0202.
//  rd_n,wr_n low together -> RAM unchanged, STATUS bit15=1; Reset with rd_n held low -> oe=0, no access until rd_n toggles.

Source files
------------

// File: rtl/hpi_pkg.sv
// Shared types for the HPI target: register selects, FSM states, status bit layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hpi_pkg;

   // Register selected by the 2-bit HPI address.
   typedef enum logic [1:0] {
      REG_DATA    = 2'd0,
      REG_MAILBOX = 2'd1,
      REG_ADDRESS = 2'd2,
      REG_STATUS  = 2'd3
   } hpi_reg_e;

   // Host access sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_RD_HOLD = 2'd2,
      ST_WR_HOLD = 2'd3
   } hpi_state_e;

   // STATUS register bit positions.
   localparam int STAT_IRQ_BIT   = 0;   // host-bound mailbox full
   localparam int STAT_VALID_BIT = 1;   // device-bound mailbox full
   localparam int STAT_ERR_BIT   = 15;  // sticky rd+wr collision

   function automatic logic [15:0] status_word(input logic err,
                                               input logic h2d_vld,
                                               input logic d2h_vld);
      logic [15:0] s;
      s                 = '0;
      s[STAT_ERR_BIT]   = err;
      s[STAT_VALID_BIT] = h2d_vld;
      s[STAT_IRQ_BIT]   = d2h_vld;
      return s;
   endfunction

endpackage

// File: rtl/hpi_ram.sv
// Single-port synchronous word RAM backing the HPI DATA register.
// Latency: read data appears one cycle after an enabled read; holds until the next enabled read.
// Backpressure: none; one access per cycle when en is high.
// Ports: clk; en/we/addr/wdata access request; rdata registered read word.
module hpi_ram #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   wdata,
   output logic [15:0]   rdata
);

   logic [15:0] mem [DEPTH];

   // rdata only moves on a read, so the target can hold a read word on the bus
   // for as long as the host keeps the strobe low.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/hpi_target.sv
// HPI target: strobe decode, auto-incrementing word RAM, address/mailbox/status registers.
// Latency: read data valid RD_LAT cycles after the first sampled rd_n low; writes take effect at the start cycle.
// Backpressure: none; host paces accesses with its strobes, device mailbox ports are single-cycle pulses.
// Ports: Clk/Reset; hpi_* host bus (cs/rd/wr strobes, addr, data in/out, output enable);
//        dev_mbx_* device-side mailbox (load host-bound word, pop device-bound word); dev_irq.
module hpi_target
   import hpi_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int RD_LAT = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        hpi_cs_n,
   input  logic        hpi_rd_n,
   input  logic        hpi_wr_n,
   input  logic [1:0]  hpi_addr,
   input  logic [15:0] hpi_data_in,
   output logic [15:0] hpi_data_out,
   output logic        hpi_data_oe,
   input  logic        dev_mbx_wr,
   input  logic [15:0] dev_mbx_wdata,
   input  logic        dev_mbx_rd,
   output logic [15:0] dev_mbx_rdata,
   output logic        dev_mbx_valid,
   output logic        dev_irq
);

   localparam int         AW        = $clog2(DEPTH);
   localparam logic [7:0] WAIT_INIT = 8'(RD_LAT - 1);

   hpi_state_e  state_q, state_d;
   logic [7:0]  wait_q, wait_d;
   logic        rd_n_q, wr_n_q;
   hpi_reg_e    acc_q;
   logic [15:0] hold_q;
   logic [15:0] addr_q;
   logic [15:0] h2d_dat_q, d2h_dat_q;
   logic        h2d_vld_q, d2h_vld_q;
   logic        err_q;
   logic [15:0] ram_rdata;

   hpi_reg_e    reg_sel;
   logic        start, both_low, rd_start, wr_start;
   logic        rd_end, wr_end, rd_done, wr_done;
   logic        ram_en;

   assign reg_sel  = hpi_reg_e'(hpi_addr);
   // A start needs a strobe that was high last cycle; the history regs reset
   // to "low" so a strobe held through reset cannot fire an access.
   assign start    = (state_q == ST_IDLE) && !hpi_cs_n &&
                     ((!hpi_rd_n && rd_n_q) || (!hpi_wr_n && wr_n_q));
   assign both_low = start && !hpi_rd_n && !hpi_wr_n;
   assign rd_start = start && !hpi_rd_n &&  hpi_wr_n;
   assign wr_start = start &&  hpi_rd_n && !hpi_wr_n;
   assign rd_end   = hpi_cs_n || hpi_rd_n;
   assign wr_end   = hpi_cs_n || hpi_wr_n;

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      rd_done = 1'b0;
      wr_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rd_start) begin
               // RAM word is already on ram_rdata one cycle after start, so a
               // single-cycle latency can go straight to the hold state.
               state_d = (RD_LAT == 1) ? ST_RD_HOLD : ST_RD_WAIT;
               wait_d  = WAIT_INIT;
            end else if (wr_start) begin
               state_d = ST_WR_HOLD;
            end
         end
         ST_RD_WAIT: begin
            if (rd_end) begin
               state_d = ST_IDLE;
            end else if (wait_q <= 8'd1) begin
               state_d = ST_RD_HOLD;
            end else begin
               wait_d = wait_q - 8'd1;
            end
         end
         ST_RD_HOLD: begin
            if (rd_end) begin
               state_d = ST_IDLE;
               rd_done = 1'b1;
            end
         end
         ST_WR_HOLD: begin
            if (wr_end) begin
               state_d = ST_IDLE;
               wr_done = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign ram_en = (rd_start || wr_start) && (reg_sel == REG_DATA);

   hpi_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk   (Clk),
      .en    (ram_en),
      .we    (wr_start),
      .addr  (addr_q[AW:1]),
      .wdata (hpi_data_in),
      .rdata (ram_rdata)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         wait_q    <= '0;
         rd_n_q    <= 1'b0;
         wr_n_q    <= 1'b0;
         acc_q     <= REG_DATA;
         hold_q    <= '0;
         addr_q    <= '0;
         h2d_dat_q <= '0;
         h2d_vld_q <= 1'b0;
         d2h_dat_q <= '0;
         d2h_vld_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         rd_n_q  <= hpi_rd_n;
         wr_n_q  <= hpi_wr_n;

         if (start) begin
            acc_q <= reg_sel;
         end

         // Register reads are snapshotted at start so the bus stays stable
         // even if the device updates the mailbox mid-access.
         if (rd_start) begin
            case (reg_sel)
               REG_MAILBOX: hold_q <= d2h_dat_q;
               REG_ADDRESS: hold_q <= addr_q;
               REG_STATUS:  hold_q <= status_word(err_q, h2d_vld_q, d2h_vld_q);
               default:     hold_q <= '0;
            endcase
         end

         if (both_low) begin
            err_q <= 1'b1;
         end

         if (wr_start && reg_sel == REG_ADDRESS) begin
            addr_q <= hpi_data_in;
         end else if ((rd_done || wr_done) && acc_q == REG_DATA) begin
            addr_q <= addr_q + 16'd2;
         end

         // Host write beats a same-cycle device pop.
         if (wr_start && reg_sel == REG_MAILBOX) begin
            h2d_dat_q <= hpi_data_in;
            h2d_vld_q <= 1'b1;
         end else if (dev_mbx_rd) begin
            h2d_vld_q <= 1'b0;
         end

         // Device load beats a same-cycle host read-clear.
         if (dev_mbx_wr) begin
            d2h_dat_q <= dev_mbx_wdata;
            d2h_vld_q <= 1'b1;
         end else if (rd_done && acc_q == REG_MAILBOX) begin
            d2h_vld_q <= 1'b0;
         end
      end
   end

   assign hpi_data_oe   = (state_q == ST_RD_WAIT) || (state_q == ST_RD_HOLD);
   assign hpi_data_out  = (state_q != ST_RD_HOLD) ? 16'h0000 :
                          (acc_q == REG_DATA)     ? ram_rdata : hold_q;
   assign dev_mbx_rdata = h2d_dat_q;
   assign dev_mbx_valid = h2d_vld_q;
   assign dev_irq       = d2h_vld_q;

endmodule

// File: tb/tb_hpi_target.sv
// Bench for hpi_target: directed scenarios followed by randomized host/device traffic
// checked against a register-level model (word array, address, two mailboxes, error flag).
module tb_hpi_target;

   localparam int DEPTH  = 256;
   localparam int RD_LAT = 2;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        hpi_cs_n, hpi_rd_n, hpi_wr_n;
   logic [1:0]  hpi_addr;
   logic [15:0] hpi_data_in, hpi_data_out;
   logic        hpi_data_oe;
   logic        dev_mbx_wr, dev_mbx_rd;
   logic [15:0] dev_mbx_wdata, dev_mbx_rdata;
   logic        dev_mbx_valid, dev_irq;

   hpi_target #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .hpi_cs_n      (hpi_cs_n),
      .hpi_rd_n      (hpi_rd_n),
      .hpi_wr_n      (hpi_wr_n),
      .hpi_addr      (hpi_addr),
      .hpi_data_in   (hpi_data_in),
      .hpi_data_out  (hpi_data_out),
      .hpi_data_oe   (hpi_data_oe),
      .dev_mbx_wr    (dev_mbx_wr),
      .dev_mbx_wdata (dev_mbx_wdata),
      .dev_mbx_rd    (dev_mbx_rd),
      .dev_mbx_rdata (dev_mbx_rdata),
      .dev_mbx_valid (dev_mbx_valid),
      .dev_irq       (dev_irq)
   );

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [15:0] m_mem [DEPTH];
   logic [15:0] m_addr;
   logic [15:0] m_h2d, m_d2h;
   logic        m_h2d_v, m_irq, m_err;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic int m_index();
      return (int'(m_addr) / 2) % DEPTH;
   endfunction

   function automatic logic [15:0] m_read(input logic [1:0] a);
      case (a)
         2'd0:    return m_mem[m_index()];
         2'd1:    return m_d2h;
         2'd2:    return m_addr;
         default: return {m_err, 13'b0, m_h2d_v, m_irq};
      endcase
   endfunction

   task automatic model_reset();
      m_addr  = 16'h0000;
      m_h2d   = 16'h0000;
      m_d2h   = 16'h0000;
      m_h2d_v = 1'b0;
      m_irq   = 1'b0;
      m_err   = 1'b0;
   endtask

   task automatic chk_dev(input string tag);
      chk({tag, "_valid"}, {15'b0, dev_mbx_valid}, {15'b0, m_h2d_v});
      chk({tag, "_rdata"}, dev_mbx_rdata, m_h2d);
      chk({tag, "_irq"},   {15'b0, dev_irq},       {15'b0, m_irq});
   endtask

   task automatic host_write(input logic [1:0] a, input logic [15:0] d, input bit dev_rd);
      hpi_addr    = a;
      hpi_data_in = d;
      hpi_cs_n    = 1'b0;
      hpi_wr_n    = 1'b0;
      dev_mbx_rd  = dev_rd;
      tick();
      dev_mbx_rd  = 1'b0;
      hpi_wr_n    = 1'b1;
      tick();
      hpi_cs_n    = 1'b1;
      case (a)
         2'd0: begin m_mem[m_index()] = d; m_addr = m_addr + 16'd2; end
         2'd1: begin m_h2d = d; m_h2d_v = 1'b1; end
         2'd2: m_addr = d;
         default: ;
      endcase
      if (dev_rd && a != 2'd1) m_h2d_v = 1'b0;
   endtask

   task automatic host_read(input logic [1:0] a, input int hold, input bit dev_wr_end,
                            input logic [15:0] dev_wd, output logic [15:0] got);
      logic [15:0] exp;
      exp      = m_read(a);
      hpi_addr = a;
      hpi_cs_n = 1'b0;
      hpi_rd_n = 1'b0;
      tick();
      for (int k = 1; k < RD_LAT; k++) begin
         chk("rd_oe_wait",   {15'b0, hpi_data_oe}, 16'h0001);
         chk("rd_dout_wait", hpi_data_out, 16'h0000);
         tick();
      end
      chk("rd_oe_valid", {15'b0, hpi_data_oe}, 16'h0001);
      got = hpi_data_out;
      chk($sformatf("rd_data_a%0d", a), got, exp);
      for (int k = 0; k < hold; k++) begin
         tick();
         chk("rd_stable", hpi_data_out, exp);
      end
      hpi_rd_n = 1'b1;
      if (dev_wr_end) begin
         dev_mbx_wr    = 1'b1;
         dev_mbx_wdata = dev_wd;
      end
      tick();
      dev_mbx_wr = 1'b0;
      chk("rd_oe_off", {15'b0, hpi_data_oe}, 16'h0000);
      hpi_cs_n = 1'b1;
      if (a == 2'd0) m_addr = m_addr + 16'd2;
      if (a == 2'd1) m_irq = 1'b0;
      if (dev_wr_end) begin m_d2h = dev_wd; m_irq = 1'b1; end
   endtask

   task automatic dev_write(input logic [15:0] d);
      dev_mbx_wr    = 1'b1;
      dev_mbx_wdata = d;
      tick();
      dev_mbx_wr = 1'b0;
      m_d2h = d;
      m_irq = 1'b1;
   endtask

   task automatic dev_pop();
      dev_mbx_rd = 1'b1;
      tick();
      dev_mbx_rd = 1'b0;
      m_h2d_v = 1'b0;
   endtask

   initial begin
      logic [15:0] got;
      hpi_cs_n = 1'b1; hpi_rd_n = 1'b1; hpi_wr_n = 1'b1;
      hpi_addr = 2'd0; hpi_data_in = 16'h0000;
      dev_mbx_wr = 1'b0; dev_mbx_rd = 1'b0; dev_mbx_wdata = 16'h0000;
      Reset = 1'b1;
      model_reset();
      tick(); tick(); tick();
      Reset = 1'b0;
      tick();

      // Reset state
      chk("rst_oe",   {15'b0, hpi_data_oe}, 16'h0000);
      chk("rst_dout", hpi_data_out, 16'h0000);
      chk_dev("rst");

      // Fill the RAM so every later read has a known word
      host_write(2'd2, 16'h0000, 1'b0);
      for (int i = 0; i < DEPTH; i++) host_write(2'd0, 16'($urandom), 1'b0);

      // Auto-increment write/read
      host_write(2'd2, 16'h0010, 1'b0);
      host_write(2'd0, 16'hBEEF, 1'b0);
      host_write(2'd0, 16'h1234, 1'b0);
      host_write(2'd2, 16'h0010, 1'b0);
      host_read(2'd0, 1, 1'b0, 16'h0, got);
      chk("incr_rd0", got, 16'hBEEF);
      host_read(2'd0, 0, 1'b0, 16'h0, got);
      chk("incr_rd1", got, 16'h1234);
      host_read(2'd2, 0, 1'b0, 16'h0, got);
      chk("incr_addr", got, 16'h0014);

      // Device-bound mailbox
      host_write(2'd1, 16'hA5A5, 1'b0);
      chk_dev("h2d_load");
      host_read(2'd3, 0, 1'b0, 16'h0, got);
      chk("h2d_status", got, 16'h0002);
      dev_pop();
      chk_dev("h2d_pop");

      // Host-bound mailbox, plain and with device load at the end cycle
      dev_write(16'h5A5A);
      chk_dev("d2h_load");
      host_read(2'd1, 2, 1'b0, 16'h0, got);
      chk("d2h_rd", got, 16'h5A5A);
      chk_dev("d2h_clr");
      dev_write(16'h7777);
      host_read(2'd1, 1, 1'b1, 16'h3C3C, got);
      chk("d2h_rd_old", got, 16'h7777);
      chk_dev("d2h_race");
      host_read(2'd1, 0, 1'b0, 16'h0, got);
      chk("d2h_rd_new", got, 16'h3C3C);

      // Host mailbox write against a same-cycle device pop
      host_write(2'd1, 16'h0F0F, 1'b1);
      chk_dev("h2d_race");
      dev_pop();

      // RAM index wrap
      host_write(2'd2, 16'h01FE, 1'b0);
      host_write(2'd0, 16'h1111, 1'b0);
      host_write(2'd0, 16'h2222, 1'b0);
      host_read(2'd2, 0, 1'b0, 16'h0, got);
      chk("wrap_addr", got, 16'h0202);
      host_write(2'd2, 16'h01FE, 1'b0);
      host_read(2'd0, 0, 1'b0, 16'h0, got);
      chk("wrap_ram255", got, 16'h1111);
      host_read(2'd0, 0, 1'b0, 16'h0, got);
      chk("wrap_ram0", got, 16'h2222);

      // rd and wr falling together: no access, sticky error
      host_write(2'd2, 16'h0020, 1'b0);
      hpi_addr = 2'd0; hpi_data_in = 16'hDEAD;
      hpi_cs_n = 1'b0; hpi_rd_n = 1'b0; hpi_wr_n = 1'b0;
      tick();
      chk("both_oe", {15'b0, hpi_data_oe}, 16'h0000);
      hpi_rd_n = 1'b1; hpi_wr_n = 1'b1;
      tick();
      hpi_cs_n = 1'b1;
      m_err = 1'b1;
      host_read(2'd3, 0, 1'b0, 16'h0, got);
      chk("both_err_bit", {15'b0, got[15]}, 16'h0001);
      host_read(2'd0, 0, 1'b0, 16'h0, got);
      chk("both_ram_keep", {15'b0, got === 16'hDEAD}, 16'h0000);

      // Reset in the middle of a read, strobe held low through and after reset
      hpi_addr = 2'd0; hpi_cs_n = 1'b0; hpi_rd_n = 1'b0;
      tick();
      chk("mid_oe_on", {15'b0, hpi_data_oe}, 16'h0001);
      Reset = 1'b1;
      tick();
      chk("mid_oe_rst", {15'b0, hpi_data_oe}, 16'h0000);
      Reset = 1'b0;
      model_reset();
      tick();
      chk("held_oe0", {15'b0, hpi_data_oe}, 16'h0000);
      tick();
      chk("held_oe1", {15'b0, hpi_data_oe}, 16'h0000);
      hpi_rd_n = 1'b1;
      tick();
      hpi_cs_n = 1'b1;
      chk_dev("post_rst");
      host_read(2'd3, 0, 1'b0, 16'h0, got);
      chk("post_rst_status", got, 16'h0000);
      host_read(2'd0, 0, 1'b0, 16'h0, got);

      // Randomized traffic against the model
      for (int it = 0; it < 300; it++) begin
         case ($urandom_range(0, 7))
            0: host_write(2'd0, 16'($urandom), 1'b0);
            1: host_read(2'd0, int'($urandom_range(0, 2)), 1'b0, 16'h0, got);
            2: host_write(2'd2, 16'($urandom), 1'b0);
            3: host_read(2'd2, 0, 1'b0, 16'h0, got);
            4: host_read(2'd3, int'($urandom_range(0, 1)), 1'b0, 16'h0, got);
            5: host_write(2'd1, 16'($urandom), 1'($urandom_range(0, 1)));
            6: host_read(2'd1, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                         16'($urandom), got);
            default: begin
               if ($urandom_range(0, 1) == 1) dev_write(16'($urandom));
               else dev_pop();
            end
         endcase
         chk_dev("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
